// File: rtl/keypad_entry_controller_if.sv
// Keypad entry bus: raw key lines and control in, BCD cook time and status out.
interface keypad_entry_controller_if;
    logic [9:0] keypad;
    logic       clear;
    logic       lock;
    logic [3:0] min_tens;
    logic [3:0] min_ones;
    logic [3:0] sec_tens;
    logic [3:0] sec_ones;
    logic       digit_strobe;
    logic [3:0] last_digit;
    logic       entry_full;
    logic       time_valid;

    modport master (
        output keypad, clear, lock,
        input  min_tens, min_ones, sec_tens, sec_ones,
        input  digit_strobe, last_digit, entry_full, time_valid
    );

    modport slave (
        input  keypad, clear, lock,
        output min_tens, min_ones, sec_tens, sec_ones,
        output digit_strobe, last_digit, entry_full, time_valid
    );
endinterface

// File: rtl/keypad_entry_controller.sv
// Keypad entry controller: debounces a 10-key pad, rejects multi-key presses
// and shifts accepted digits into a 4-digit BCD MM:SS cook-time register.
module keypad_entry_controller #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int CNT_W           = 3
) (
    input  logic                      clk,
    input  logic                      resetn,
    keypad_entry_controller_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        DEBOUNCE = 2'd1,
        RELEASE  = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] LP_LAST = CNT_W'(DEBOUNCE_CYCLES);

    state_t           r_state;
    state_t           w_next_state;
    logic [9:0]       r_sample;
    logic [9:0]       w_next_sample;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_next_cnt;
    logic [CNT_W-1:0] w_cnt_inc;
    logic             w_legal;
    logic             w_key_zero;
    logic             w_accept;
    logic [3:0]       w_code;

    logic [3:0]       r_min_tens;
    logic [3:0]       r_min_ones;
    logic [3:0]       r_sec_tens;
    logic [3:0]       r_sec_ones;
    logic [3:0]       r_last_digit;
    logic [2:0]       r_count;
    logic             r_strobe;
    logic             r_full;
    logic             r_valid;

    // A legal keypad has exactly one line high.
    assign w_key_zero = (bus.keypad == 10'd0);
    assign w_legal    = !w_key_zero && ((bus.keypad & (bus.keypad - 10'd1)) == 10'd0);
    assign w_cnt_inc  = r_cnt + CNT_W'(1);

    // State, latched key sample and debounce counter.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state  <= IDLE;
            r_sample <= 10'd0;
            r_cnt    <= '0;
        end else begin
            r_state  <= w_next_state;
            r_sample <= w_next_sample;
            r_cnt    <= w_next_cnt;
        end
    end

    // Next-state logic; clear beats lock, lock beats normal sequencing.
    always_comb begin
        w_next_state  = r_state;
        w_next_sample = r_sample;
        w_next_cnt    = r_cnt;
        w_accept      = 1'b0;
        if (bus.clear) begin
            w_next_state = (bus.lock || !w_key_zero) ? RELEASE : IDLE;
            w_next_cnt   = '0;
        end else if (bus.lock) begin
            w_next_state = RELEASE;
            w_next_cnt   = '0;
        end else begin
            unique case (r_state)
                IDLE: begin
                    if (w_legal) begin
                        w_next_sample = bus.keypad;
                        if (DEBOUNCE_CYCLES <= 1) begin
                            w_accept     = 1'b1;
                            w_next_state = RELEASE;
                            w_next_cnt   = '0;
                        end else begin
                            w_next_state = DEBOUNCE;
                            w_next_cnt   = CNT_W'(1);
                        end
                    end
                end
                DEBOUNCE: begin
                    if (bus.keypad == r_sample) begin
                        if (w_cnt_inc == LP_LAST) begin
                            w_accept     = 1'b1;
                            w_next_state = RELEASE;
                            w_next_cnt   = '0;
                        end else begin
                            w_next_cnt = w_cnt_inc;
                        end
                    end else begin
                        w_next_state = IDLE;
                        w_next_cnt   = '0;
                    end
                end
                RELEASE: begin
                    if (w_key_zero) begin
                        if (w_cnt_inc == LP_LAST) begin
                            w_next_state = IDLE;
                            w_next_cnt   = '0;
                        end else begin
                            w_next_cnt = w_cnt_inc;
                        end
                    end else begin
                        w_next_cnt = '0;
                    end
                end
                default: begin
                    w_next_state = IDLE;
                    w_next_cnt   = '0;
                end
            endcase
        end
    end

    // One-hot to BCD encode of the key being accepted.
    always_comb begin
        w_code = 4'd0;
        for (int k = 0; k < 10; k++) begin
            if (w_next_sample[k]) begin
                w_code = 4'(k);
            end
        end
    end

    // Digit shift register, entry count, strobe and status flags.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_min_tens   <= 4'd0;
            r_min_ones   <= 4'd0;
            r_sec_tens   <= 4'd0;
            r_sec_ones   <= 4'd0;
            r_last_digit <= 4'd0;
            r_count      <= 3'd0;
            r_strobe     <= 1'b0;
            r_full       <= 1'b0;
            r_valid      <= 1'b0;
        end else if (bus.clear) begin
            r_min_tens   <= 4'd0;
            r_min_ones   <= 4'd0;
            r_sec_tens   <= 4'd0;
            r_sec_ones   <= 4'd0;
            r_last_digit <= 4'd0;
            r_count      <= 3'd0;
            r_strobe     <= 1'b0;
            r_full       <= 1'b0;
            r_valid      <= 1'b0;
        end else begin
            r_strobe <= 1'b0;
            if (w_accept && (r_count != 3'd4)) begin
                r_min_tens   <= r_min_ones;
                r_min_ones   <= r_sec_tens;
                r_sec_tens   <= r_sec_ones;
                r_sec_ones   <= w_code;
                r_last_digit <= w_code;
                r_count      <= r_count + 3'd1;
                r_strobe     <= 1'b1;
                r_full       <= (r_count == 3'd3);
                r_valid      <= 1'b1;
            end
        end
    end

    assign bus.min_tens     = r_min_tens;
    assign bus.min_ones     = r_min_ones;
    assign bus.sec_tens     = r_sec_tens;
    assign bus.sec_ones     = r_sec_ones;
    assign bus.last_digit   = r_last_digit;
    assign bus.digit_strobe = r_strobe;
    assign bus.entry_full   = r_full;
    assign bus.time_valid   = r_valid;

endmodule
